// File: rtl/top_bus_frontend.sv
// MCU bus front end: synchronizes the async ale/write/read strobes, queues writes for the engine,
// fetches engine read data and answers ID/status reads locally. Optional macro: BUS_GLITCH_FILTER_EN.
module top_bus_frontend #(
    parameter logic [15:0] RUNTIME_ID  = 16'h0000,
    parameter logic [7:0]  RUNTIME_REV = 8'h01,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       osc,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic       ale,
    input  logic       write,
    input  logic       read,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STRB_W = 3;
    localparam int unsigned ALE_B  = 2;
    localparam int unsigned WR_B   = 1;
    localparam int unsigned RD_B   = 0;
    localparam logic [STRB_W-1:0] STRB_IDLE = 3'b011;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    // 2-FF synchronizers plus a third stage for edge detection
    logic [STRB_W-1:0] strb_s1, strb_s2, strb_s3;
    logic [7:0]        data_s1, data_s2;

    always_ff @(posedge osc) begin
        if (rst) begin
            strb_s1 <= STRB_IDLE;
            strb_s2 <= STRB_IDLE;
            strb_s3 <= STRB_IDLE;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            strb_s1 <= {ale, write, read};
            strb_s2 <= strb_s1;
            strb_s3 <= strb_s2;
            data_s1 <= data_in;
            data_s2 <= data_s1;
        end
    end

    logic [STRB_W-1:0] strb_lvl;
    logic [STRB_W-1:0] strb_prev;

`ifdef BUS_GLITCH_FILTER_EN
    logic [STRB_W-1:0] strb_acc;

    // A new level is taken only once two consecutive samples agree
    always_comb begin
        strb_lvl = (strb_s2 & strb_s3) | (strb_acc & (strb_s2 | strb_s3));
    end

    assign strb_prev = strb_acc;

    always_ff @(posedge osc) begin
        if (rst) begin
            strb_acc <= STRB_IDLE;
        end else begin
            strb_acc <= strb_lvl;
        end
    end
`else
    assign strb_lvl  = strb_s2;
    assign strb_prev = strb_s3;
`endif

    logic ale_fall, write_rise, read_fall;

    assign ale_fall   = strb_prev[ALE_B] & ~strb_lvl[ALE_B];
    assign write_rise = ~strb_prev[WR_B] & strb_lvl[WR_B];
    assign read_fall  = strb_prev[RD_B] & ~strb_lvl[RD_B];

    // Address latch; same-cycle WRITE/READ still see the previous address
    logic [7:0] address;

    always_ff @(posedge osc) begin
        if (rst) begin
            address <= '0;
        end else if (ale_fall) begin
            address <= data_s2;
        end
    end

    // Write-command FIFO
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic             fifo_full, do_push, do_pop, push_drop;

    always_comb begin
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        do_pop     = cmd_valid & cmd_ready;
        do_push    = write_rise & (~fifo_full | do_pop);
        push_drop  = write_rise & fifo_full & ~do_pop;
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_valid <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count_next;
            cmd_valid <= (count_next != '0);
        end
    end

    always_ff @(posedge osc) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= cmd_t'{addr: address, data: data_s2};
        end
    end

    assign cmd_addr = fifo_mem[rd_ptr].addr;
    assign cmd_data = fifo_mem[rd_ptr].data;

    // Local register window at 0xFC..0xFF
    logic       local_hit;
    logic [7:0] local_data;

    always_comb begin
        local_hit = (address[7:2] == 6'h3F);
        case (address[1:0])
            2'd0:    local_data = {7'b0, overflow};
            2'd1:    local_data = RUNTIME_ID[7:0];
            2'd2:    local_data = RUNTIME_ID[15:8];
            default: local_data = RUNTIME_REV;
        endcase
    end

    logic [7:0] read_data;

    always_ff @(posedge osc) begin
        if (rst) begin
            read_data <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            overflow  <= 1'b0;
        end else begin
            rd_req <= 1'b0;
            if (rd_req) begin
                read_data <= rd_data;
            end
            if (read_fall) begin
                if (local_hit) begin
                    read_data <= local_data;
                end else begin
                    rd_req  <= 1'b1;
                    rd_addr <= address;
                end
            end
            // A drop in the same cycle as a status read keeps the flag set
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (read_fall && local_hit && (address[1:0] == 2'd0)) begin
                overflow <= 1'b0;
            end
        end
    end

    assign data_out = read_data;
    assign data_oe  = ~read & address[4];

endmodule

// File: tb/tb_top_bus_frontend.sv
// Scoreboard bench for top_bus_frontend: directed bus transactions followed by randomized traffic,
// checked against a transaction-level model of the bus front end.
module tb_top_bus_frontend;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] RID   = 16'h0012;
    localparam logic [7:0]  RREV  = 8'h01;
`ifdef BUS_GLITCH_FILTER_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 3;
`endif

    logic       osc = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       data_oe;
    logic       ale = 1'b0;
    logic       write = 1'b1;
    logic       read = 1'b1;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = '0;
    logic       overflow;

    top_bus_frontend #(
        .RUNTIME_ID (RID),
        .RUNTIME_REV(RREV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .osc      (osc),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .ale      (ale),
        .write    (write),
        .read     (read),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .overflow (overflow)
    );

    always #5 osc = ~osc;

    int n_checks = 0;
    int n_fail   = 0;
    int pops     = 0;
    bit rand_ready = 1'b0;

    // Transaction-level model state
    logic [7:0]  m_addr = '0;
    bit          m_ovf  = 1'b0;
    logic [15:0] exp_cmd[$];
    logic [7:0]  exp_req[$];
    logic [8:0]  exp_rd[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge osc);
            if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic void model_write(input logic [7:0] d, input bit pop_same);
        if (exp_cmd.size() < DEPTH || pop_same) exp_cmd.push_back({m_addr, d});
        else m_ovf = 1'b1;
    endfunction

    task automatic set_addr(input logic [7:0] a);
        data_in = a;
        cyc(1);
        ale = 1'b1;
        cyc(3);
        ale = 1'b0;
        m_addr = a;
        cyc(4);
    endtask

    // pop_same: hold cmd_ready for exactly the cycle in which the push lands
    task automatic bus_write(input logic [7:0] d, input bit pop_same);
        data_in = d;
        cyc(1);
        write = 1'b0;
        cyc(3);
        write = 1'b1;
        model_write(d, pop_same);
        if (pop_same) begin
            cyc(LAT - 1);
            cmd_ready = 1'b1;
            cyc(1);
            cmd_ready = 1'b0;
            cyc(4);
        end else begin
            cyc(5);
        end
    endtask

    task automatic bus_read(input logic [7:0] eng);
        logic [7:0] v;
        if (m_addr >= 8'hFC) begin
            case (m_addr)
                8'hFC:   begin v = {7'b0, m_ovf}; m_ovf = 1'b0; end
                8'hFD:   v = RID[7:0];
                8'hFE:   v = RID[15:8];
                default: v = RREV;
            endcase
            rd_data = ~v;
        end else begin
            v = eng;
            rd_data = eng;
            exp_req.push_back(m_addr);
        end
        exp_rd.push_back({m_addr[4], v});
        read = 1'b0;
        cyc(8);
        read = 1'b1;
        cyc(4);
    endtask

    task automatic combo_ale_write(input logic [7:0] a);
        data_in = a;
        cyc(1);
        write = 1'b0;
        ale = 1'b1;
        cyc(3);
        ale = 1'b0;
        write = 1'b1;
        model_write(a, 1'b0);
        m_addr = a;
        cyc(5);
    endtask

    task automatic drain(input string name, input int exp_n);
        int start;
        int t;
        start = pops;
        t = 0;
        cmd_ready = 1'b1;
        while ((cmd_valid || exp_cmd.size() != 0) && t < 40) begin
            cyc(1);
            t++;
        end
        cmd_ready = 1'b0;
        cyc(1);
        if (t >= 40) fail_now({name, "_drain_timeout"});
        chk({name, "_pops"}, 16'(pops - start), 16'(exp_n));
    endtask

    // Monitor: compares every DUT presentation against the scoreboard queues
    initial begin : monitor
        int  rlow;
        bit  prev_req;
        logic [15:0] ec;
        logic [7:0]  er;
        logic [8:0]  ed;
        rlow = 0;
        prev_req = 1'b0;
        forever begin
            @(negedge osc);
            #4;
            if (rst) begin
                rlow = 0;
                prev_req = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    pops++;
                    if (exp_cmd.size() == 0) begin
                        fail_now("cmd_unexpected");
                    end else begin
                        ec = exp_cmd.pop_front();
                        chk("cmd_entry", {cmd_addr, cmd_data}, ec);
                    end
                end
                if (rd_req) begin
                    if (exp_req.size() == 0) begin
                        fail_now("rd_req_unexpected");
                    end else begin
                        er = exp_req.pop_front();
                        chk("rd_addr", 16'(rd_addr), 16'(er));
                    end
                end
                if (rd_req && prev_req) fail_now("rd_req_width");
                prev_req = rd_req;
                if (!read) rlow++;
                else rlow = 0;
                if (rlow == 6) begin
                    if (exp_rd.size() == 0) begin
                        fail_now("read_unexpected");
                    end else begin
                        ed = exp_rd.pop_front();
                        chk("read_bus", 16'({data_oe, data_out}), 16'(ed));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int t;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        chk("rst_data_out", 16'(data_out), 16'h0);
        chk("rst_data_oe", 16'(data_oe), 16'h0);
        chk("rst_cmd_valid", 16'(cmd_valid), 16'h0);
        chk("rst_rd_req", 16'(rd_req), 16'h0);
        chk("rst_overflow", 16'(overflow), 16'h0);

        // Write latency and head contents
        set_addr(8'h10);
        data_in = 8'hA5;
        cyc(1);
        write = 1'b0;
        cyc(3);
        write = 1'b1;
        model_write(8'hA5, 1'b0);
        cyc(LAT - 1);
        chk("cmd_valid_early", 16'(cmd_valid), 16'h0);
        cyc(1);
        chk("cmd_valid_latency", 16'(cmd_valid), 16'h1);
        chk("cmd_head", {cmd_addr, cmd_data}, 16'h10A5);
        cyc(3);
        drain("single", 1);

        // Overflow and status read
        set_addr(8'h20);
        for (int d = 1; d <= 5; d++) bus_write(8'(d), 1'b0);
        chk("overflow_set", 16'(overflow), 16'(m_ovf));
        set_addr(8'hFC);
        bus_read(8'h00);
        chk("overflow_cleared", 16'(overflow), 16'(m_ovf));
        drain("overflow_fifo", 4);

        // Full FIFO with a pop landing on the push cycle
        set_addr(8'h30);
        for (int d = 8'h11; d <= 8'h14; d++) bus_write(8'(d), 1'b0);
        bus_write(8'h15, 1'b1);
        chk("full_pushpop_ovf", 16'(overflow), 16'h0);
        chk("full_pushpop_valid", 16'(cmd_valid), 16'h1);
        drain("full_pushpop", 4);

        // Runtime ID / revision
        set_addr(8'hFD);
        bus_read(8'h00);
        set_addr(8'hFE);
        bus_read(8'h00);
        set_addr(8'hFF);
        bus_read(8'h00);

        // Engine reads
        set_addr(8'h10);
        bus_read(8'h3C);
        chk("oe_released", 16'(data_oe), 16'h0);
        set_addr(8'h05);
        bus_read(8'h5A);

        // ALE fall and WRITE rise in the same cycle
        set_addr(8'h40);
        combo_ale_write(8'h77);
        bus_read(8'h99);
        drain("combo", 1);

`ifdef BUS_GLITCH_FILTER_EN
        write = 1'b0;
        cyc(1);
        write = 1'b1;
        cyc(6);
        chk("glitch_rejected", 16'(cmd_valid), 16'h0);
`endif

        // Reset while entries are queued
        set_addr(8'h50);
        for (int d = 0; d < 5; d++) bus_write(8'(8'h60 + d), 1'b0);
        chk("pre_rst_overflow", 16'(overflow), 16'h1);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_cmd_valid", 16'(cmd_valid), 16'h0);
        chk("mid_rst_overflow", 16'(overflow), 16'h0);
        rst = 1'b0;
        exp_cmd.delete();
        m_ovf = 1'b0;
        m_addr = 8'h00;
        cyc(3);
        bus_read(8'hC3);
        bus_write(8'h66, 1'b0);
        drain("post_rst", 1);

        // Randomized traffic with a randomly stalling engine
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    if ($urandom_range(0, 9) < 3) set_addr(8'(8'hFC + $urandom_range(0, 3)));
                    else set_addr(8'($urandom));
                end
                2, 3: begin
                    t = 0;
                    while (exp_cmd.size() >= DEPTH && t < 100) begin
                        cyc(1);
                        t++;
                    end
                    if (t >= 100) fail_now("fifo_wait_timeout");
                    bus_write(8'($urandom), 1'b0);
                end
                default: bus_read(8'($urandom));
            endcase
            chk("rand_overflow", 16'(overflow), 16'(m_ovf));
        end
        rand_ready = 1'b0;
        cmd_ready = 1'b0;
        cyc(2);
        n = exp_cmd.size();
        drain("random", n);
        chk("leftover_rd_req", 16'(exp_req.size()), 16'h0);
        chk("leftover_reads", 16'(exp_rd.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
